pwm_multichannel: RTL and testbench

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

---
 rtl/pwm_multichannel.sv | 163 ++++++++++++++++
 tb/tb_pwm_multichannel.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator: one shared prescaled period counter (edge or center aligned)
// feeding per-channel double-buffered duty registers and registered outputs.
module pwm_multichannel #(
    parameter int NUM_CH = 16,
    parameter int RES    = 8,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [4:0]        wr_ch,
    input  logic [1:0]        wr_sel,
    input  logic [RES-1:0]    wr_data,
    input  logic [PRE_W-1:0]  cfg_prescale,
    output logic [NUM_CH-1:0] out,
    output logic              period_start,
    output logic [RES-1:0]    cnt
);

    localparam logic [RES-1:0] CNT_MAX    = '1;
    localparam logic [RES-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;
    localparam logic [RES-1:0] CNT_ONE    = RES'(1);
    localparam logic [5:0]     NUM_CH_W   = 6'(NUM_CH);

    localparam logic [1:0] SEL_DUTY   = 2'd0;
    localparam logic [1:0] SEL_EN_OUT = 2'd1;
    localparam logic [1:0] SEL_EN_PWM = 2'd2;
    localparam logic [1:0] SEL_CFG    = 2'd3;

    logic [PRE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [PRE_W-1:0] cfg_prescale_q;
    logic             center_q, center_d;
    logic             center_pend_q, center_pend_d;
    logic [RES-1:0]   cnt_q, cnt_d;
    logic             down_q, down_d;
    logic             period_start_q, period_start_d;
    logic             tick;
    logic             boundary;
    logic             wr_ch_ok;

    assign wr_ch_ok = ({1'b0, wr_ch} < NUM_CH_W);

    always_comb begin
        tick        = (presc_cnt_q == prescale_q);
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        cnt_d       = cnt_q;
        down_d      = down_q;
        boundary    = 1'b0;
        if (tick) begin
            if (!center_q) begin
                down_d = 1'b0;
                if (cnt_q >= CNT_MAX_M1) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (!down_q) begin
                // Peak at MAX is visited once, then the down slope starts at MAX-1
                if (cnt_q == CNT_MAX) begin
                    cnt_d  = CNT_MAX_M1;
                    down_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q <= CNT_ONE) begin
                    cnt_d    = '0;
                    down_d   = 1'b0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // Shadowed config is only committed at a boundary, using the value held before that cycle
    always_comb begin
        period_start_d = boundary;
        prescale_d     = boundary ? cfg_prescale_q : prescale_q;
        center_d       = boundary ? center_pend_q : center_q;
        center_pend_d  = center_pend_q;
        if (wr_en && (wr_sel == SEL_CFG)) begin
            center_pend_d = wr_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_cnt_q    <= '0;
            prescale_q     <= '0;
            cfg_prescale_q <= '0;
            center_q       <= 1'b0;
            center_pend_q  <= 1'b0;
            cnt_q          <= '0;
            down_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            presc_cnt_q    <= presc_cnt_d;
            prescale_q     <= prescale_d;
            cfg_prescale_q <= cfg_prescale;
            center_q       <= center_d;
            center_pend_q  <= center_pend_d;
            cnt_q          <= cnt_d;
            down_q         <= down_d;
            period_start_q <= period_start_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [RES-1:0] duty_pend_q, duty_pend_d;
        logic [RES-1:0] duty_act_q, duty_act_d;
        logic           en_out_q, en_out_d;
        logic           en_pwm_q, en_pwm_d;
        logic           out_q, out_d;
        logic           wr_hit;
        logic           pwm_lvl;

        assign wr_hit = wr_en && wr_ch_ok && (wr_ch == 5'(gi));

        always_comb begin
            duty_pend_d = duty_pend_q;
            en_out_d    = en_out_q;
            en_pwm_d    = en_pwm_q;
            if (wr_hit) begin
                case (wr_sel)
                    SEL_DUTY:   duty_pend_d = wr_data;
                    SEL_EN_OUT: en_out_d    = wr_data[0];
                    SEL_EN_PWM: en_pwm_d    = wr_data[0];
                    default:    ;
                endcase
            end
            duty_act_d = boundary ? duty_pend_q : duty_act_q;
            // Full-scale duty must stay high even at the center-mode peak where cnt == MAX
            pwm_lvl    = (duty_act_q == CNT_MAX) || (cnt_q < duty_act_q);
            out_d      = en_out_q && (!en_pwm_q || pwm_lvl);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                duty_pend_q <= '0;
                duty_act_q  <= '0;
                en_out_q    <= 1'b0;
                en_pwm_q    <= 1'b0;
                out_q       <= 1'b0;
            end else begin
                duty_pend_q <= duty_pend_d;
                duty_act_q  <= duty_act_d;
                en_out_q    <= en_out_d;
                en_pwm_q    <= en_pwm_d;
                out_q       <= out_d;
            end
        end

        assign out[gi] = out_q;
    end

    assign period_start = period_start_q;
    assign cnt          = cnt_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: a period-phase reference model predicts every cycle's
// outputs into a queue; an independent monitor pops and compares after each clock edge.
module tb_pwm_multichannel;

    localparam int NUM_CH = 16;
    localparam int RES    = 8;
    localparam int PRE_W  = 8;
    localparam int MAXV   = (1 << RES) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [4:0]        wr_ch;
    logic [1:0]        wr_sel;
    logic [RES-1:0]    wr_data;
    logic [PRE_W-1:0]  cfg_prescale;
    logic [NUM_CH-1:0] out;
    logic              period_start;
    logic [RES-1:0]    cnt;

    always #5 clk = ~clk;

    pwm_multichannel #(.NUM_CH(NUM_CH), .RES(RES), .PRE_W(PRE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .cfg_prescale (cfg_prescale),
        .out          (out),
        .period_start (period_start),
        .cnt          (cnt)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] out;
        logic              ps;
        logic [RES-1:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle_no = 0;

    // Reference model: position within the period in ticks, plus clocks since last tick
    int  m_phase, m_div, m_p, m_prev_cfg;
    bit  m_center, m_center_pend;
    int  m_pend[NUM_CH];
    int  m_act[NUM_CH];
    bit  m_eo[NUM_CH];
    bit  m_ep[NUM_CH];

    function automatic int m_len();
        return m_center ? 2 * MAXV : MAXV;
    endfunction

    function automatic int m_cnt();
        if (!m_center) return m_phase;
        return (m_phase <= MAXV) ? m_phase : 2 * MAXV - m_phase;
    endfunction

    function automatic bit m_boundary_next();
        return (m_div == m_p) && (m_phase == m_len() - 1);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_div = 0; m_p = 0; m_prev_cfg = 0;
        m_center = 0; m_center_pend = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 0; m_act[i] = 0; m_eo[i] = 0; m_ep[i] = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit we, input int ch, input int sel,
                              input int data, input int cfg);
        exp_t e;
        int   c;
        bit   lvl, tk, b;
        e = '0;
        if (!r) begin
            model_reset();
        end else begin
            c = m_cnt();
            for (int i = 0; i < NUM_CH; i++) begin
                lvl = (m_act[i] == MAXV) || (c < m_act[i]);
                e.out[i] = m_eo[i] && (!m_ep[i] || lvl);
            end
            tk = (m_div == m_p);
            b  = m_boundary_next();
            m_div = tk ? 0 : m_div + 1;
            if (tk) m_phase = b ? 0 : m_phase + 1;
            if (b) begin
                for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
                m_center = m_center_pend;
                m_p      = m_prev_cfg;
            end
            e.ps = b;
            if (we) begin
                if (sel == 3) m_center_pend = data[0];
                else if (ch < NUM_CH) begin
                    case (sel)
                        0: m_pend[ch] = data;
                        1: m_eo[ch]   = data[0];
                        default: m_ep[ch] = data[0];
                    endcase
                end
            end
            m_prev_cfg = cfg;
            e.cnt = RES'(m_cnt());
        end
        exp_q.push_back(e);
    endtask

    // Called at a falling edge: present inputs, predict the next rising edge, wait a cycle
    task automatic drive(input logic w, input logic [4:0] ch, input logic [1:0] sel,
                         input logic [RES-1:0] d);
        wr_en = w; wr_ch = ch; wr_sel = sel; wr_data = d;
        model_step(rst_n, w, int'(ch), int'(sel), int'(d), int'(cfg_prescale));
        if (w && rst_n)
            $display("wr cyc=%0d ch=%0d sel=%0d data=%0d prescale=%0d", cycle_no, ch, sel, d, cfg_prescale);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 5'd0, 2'd0, '0);
    endtask

    task automatic wait_boundary(input int budget);
        int k;
        k = 0;
        while (!m_boundary_next() && k < budget) begin
            idle(1);
            k++;
        end
        if (!m_boundary_next()) begin
            n_checks++;
            $display("FAIL boundary_wait: no boundary within %0d cycles, phase=%0d", budget, m_phase);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out !== e.out || period_start !== e.ps || cnt !== e.cnt)
                    $display("FAIL cycle_chk cyc=%0d: got out=%h ps=%b cnt=%0d, want out=%h ps=%b cnt=%0d",
                             cycle_no, out, period_start, cnt, e.out, e.ps, e.cnt);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        int r;
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0; cfg_prescale = '0;
        model_reset();
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Edge mode, prescale 0: ch0 50% duty, ch1 duty 0, ch2 full scale
        drive(1'b1, 5'd0, 2'd0, 8'd128);
        drive(1'b1, 5'd0, 2'd1, 8'd1);
        drive(1'b1, 5'd0, 2'd2, 8'd1);
        drive(1'b1, 5'd1, 2'd0, 8'd0);
        drive(1'b1, 5'd1, 2'd1, 8'd1);
        drive(1'b1, 5'd1, 2'd2, 8'd1);
        drive(1'b1, 5'd2, 2'd0, 8'd255);
        drive(1'b1, 5'd2, 2'd1, 8'd1);
        drive(1'b1, 5'd2, 2'd2, 8'd1);
        idle(800);

        // Static high without PWM, and an output-disabled channel with a duty set
        drive(1'b1, 5'd3, 2'd1, 8'd1);
        drive(1'b1, 5'd4, 2'd0, 8'd200);
        drive(1'b1, 5'd4, 2'd2, 8'd1);
        idle(300);
        drive(1'b1, 5'd3, 2'd1, 8'd0);
        idle(5);

        // Out-of-range channel writes must not disturb anything
        drive(1'b1, 5'd20, 2'd0, 8'd77);
        drive(1'b1, 5'd31, 2'd1, 8'd1);
        idle(5);

        // Duty change mid-period, then a change issued exactly on the boundary cycle
        drive(1'b1, 5'd6, 2'd0, 8'd10);
        drive(1'b1, 5'd6, 2'd1, 8'd1);
        drive(1'b1, 5'd6, 2'd2, 8'd1);
        wait_boundary(600);
        idle(60);
        drive(1'b1, 5'd6, 2'd0, 8'd200);
        wait_boundary(600);
        drive(1'b1, 5'd6, 2'd0, 8'd10);
        idle(600);

        // Center mode with prescale 1, ch5 duty 64
        cfg_prescale = 8'd1;
        drive(1'b1, 5'd0, 2'd3, 8'd1);
        drive(1'b1, 5'd5, 2'd0, 8'd64);
        drive(1'b1, 5'd5, 2'd1, 8'd1);
        drive(1'b1, 5'd5, 2'd2, 8'd1);
        idle(3000);

        // Reset mid-period with a nonzero duty programmed
        drive(1'b1, 5'd7, 2'd0, 8'd100);
        drive(1'b1, 5'd7, 2'd1, 8'd1);
        drive(1'b1, 5'd7, 2'd2, 8'd1);
        idle(400);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        drive(1'b1, 5'd7, 2'd1, 8'd1);
        drive(1'b1, 5'd7, 2'd2, 8'd1);
        idle(600);

        // Randomized traffic with prescale changes and occasional resets
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 199) == 0) cfg_prescale = PRE_W'($urandom_range(0, 2));
            rst_n = ($urandom_range(0, 4999) != 0);
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 3);
                drive(1'b1, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                      (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom));
            end else begin
                idle(1);
            end
        end
        rst_n = 1'b1;
        idle(2);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
